bs_board_engine: RTL and testbench
==================================

Name: bs_board_engine

Overview:
Parametrised successor to the fixed 4x4 player-board logic inside Slave_Top. It holds one player's ship map for a ROWS x COLS grid and accepts the opponent's cumulative attack map through a valid/ready handshake. Each attack is checked for exactly one newly-set cell, then scored as a hit or miss. It tracks surviving ship cells, the accepted shot count and the alive flag, and feeds the display and UART-side control in both Master and Slave tops.

Parameters:
ROWS, 4, grid rows.
COLS, 4, grid columns; CELLS = ROWS*COLS (localparam), CNT_W = $clog2(CELLS+1) (localparam).
TIMEOUT_CYC, 1024, cycles allowed in ARMED with no accepted attack; used only with TURN_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  reset, asynchronous, active-high.
load  in  1  one-cycle request to load ships.
ships  in  CELLS  ship placement map; 1 = ship cell.
atk_valid  in  1  attack map valid.
atk_map  in  CELLS  opponent's cumulative attack map; 1 = cell attacked.
atk_ready  out  1  engine can accept an attack.
res_valid  out  1  one-cycle result pulse.
res_hit  out  1  accepted shot hit a ship; qualified by res_valid.
res_err  out  1  attack or load rejected; qualified by res_valid.
alive_map  out  CELLS  ship cells not yet hit.
live  out  1  player still has at least one ship cell.
ships_left  out  CNT_W  popcount of alive_map.
shots  out  CNT_W  number of accepted attacks.
timeout  out  1  one-cycle pulse when the turn limit expires.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - alive_map, prev_map and shots clear to 0.
  - live, atk_ready, res_valid, res_hit, res_err and timeout are 0.
  - ships_left is 0.
- States: IDLE, ARMED, CHECK, RESULT, DEAD.
- IDLE:
  - atk_ready=0; atk_valid is ignored.
  - load with ships!=0 → alive_map<=ships, prev_map<=0, shots<=0, then ARMED.
  - load with ships==0 → res_valid=1 and res_err=1 for one cycle; state stays IDLE.
- ARMED:
  - atk_ready=1 and live=1; load is ignored.
  - When atk_valid&&atk_ready at edge T, atk_map is latched into atk_q and the FSM moves to CHECK.
- CHECK (atk_ready=0):
  - new = atk_q & ~prev_map; lost = prev_map & ~atk_q.
  - err = (popcount(new)!=1) || (lost!=0).
  - hit = |(new & alive_map).
  - These values are registered, then the FSM moves to RESULT.
- RESULT (res_valid=1 for exactly one cycle, at T+2):
  - err=1:
    - res_err=1, res_hit=0.
    - No state is updated; FSM returns to ARMED.
  - err=0:
    - res_hit=hit.
    - prev_map<=atk_q, alive_map<=alive_map&~new, shots<=shots+1.
    - alive_map becomes 0 → DEAD; otherwise → ARMED.
- DEAD:
  - live=0, atk_ready=0; atk_valid is ignored.
  - load with ships!=0 starts a new game exactly as from IDLE.
- live, alive_map, ships_left and shots are registered. Their updated values become visible in the cycle after the RESULT edge (T+3). In the DEAD transition, live falls at T+3.
- shots cannot exceed CELLS because every accepted shot adds one new cell, so no saturation logic is needed.
- atk_map may change while atk_ready=0; the engine uses only the latched copy.

Optional Feature:
TURN_TIMEOUT_EN:
- Defined:
  - A counter runs in ARMED and clears on an accepted attack or on leaving ARMED.
  - When the counter reaches TIMEOUT_CYC-1, timeout pulses for one cycle, the counter clears, and the state stays ARMED.
  - clr clears the counter.
- Undefined: timeout is tied to 0 and no counter exists.

Test Plan:
- Reset and load: assert clr; release; load ships=16'h30E6 → atk_ready=1 and live=1. One cycle later, ships_left=7 and shots=0.
- First hit: atk_map=16'h2000 → at T+2 res_valid=1, res_hit=1, res_err=0. At T+3 ships_left=6, shots=1, alive_map=16'h10E6.
- Rejects:
  - Repeat atk_map=16'h2000 → res_err=1.
  - atk_map=16'h3004 (two new cells) → res_err=1.
  - atk_map=16'h0001 (cell cleared) → res_err=1.
  - After all three, ships_left=6 and shots=1 are unchanged.
- Miss: atk_map=16'h2001 → res_hit=0; shots=2, ships_left=6.
- Kill and restart:
  - Attack the remaining six ship cells one at a time → the last result has res_hit=1.
  - Then live=0 and atk_ready=0; a following atk_valid gets no response.
  - load ships=16'h0003 → ARMED, shots=0, ships_left=2.
- Async reset and timeout:
  - Assert clr during CHECK → all outputs return to reset values immediately, with no res_valid.
  - With TURN_TIMEOUT_EN and TIMEOUT_CYC=8, idle in ARMED for 8 cycles → timeout pulses once and repeats every 8 cycles.

Source files
------------

// File: rtl/bs_board_engine.sv
// bs_board_engine: one player's ship map scored against the opponent's cumulative attack map.
// Define TURN_TIMEOUT_EN to add the ARMED turn timer that drives timeout.
module bs_board_engine #(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned CELLS      = ROWS * COLS,
    localparam int unsigned CNT_W      = $clog2(CELLS + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CELLS-1:0] ships,
    input  logic             atk_valid,
    input  logic [CELLS-1:0] atk_map,
    output logic             atk_ready,
    output logic             res_valid,
    output logic             res_hit,
    output logic             res_err,
    output logic [CELLS-1:0] alive_map,
    output logic             live,
    output logic [CNT_W-1:0] ships_left,
    output logic [CNT_W-1:0] shots,
    output logic             timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CHECK,
        S_RESULT,
        S_DEAD
    } state_t;

    state_t           state;
    logic [CELLS-1:0] atk_q;
    logic [CELLS-1:0] prev_map;

    logic [CELLS-1:0] new_c;
    logic [CELLS-1:0] lost_c;
    logic [CELLS-1:0] alive_nxt_c;
    logic             one_new_c;
    logic             err_c;
    logic             hit_c;

    function automatic logic [CNT_W-1:0] popcount(input logic [CELLS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CELLS; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // A legal shot adds exactly one cell to the cumulative map and never removes one.
    always_comb begin
        new_c       = atk_q & ~prev_map;
        lost_c      = prev_map & ~atk_q;
        one_new_c   = (new_c != '0) && ((new_c & (new_c - CELLS'(1))) == '0);
        err_c       = !one_new_c || (lost_c != '0);
        hit_c       = |(new_c & alive_map);
        alive_nxt_c = alive_map & ~new_c;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= S_IDLE;
            atk_q      <= '0;
            prev_map   <= '0;
            alive_map  <= '0;
            shots      <= '0;
            ships_left <= '0;
            live       <= 1'b0;
            atk_ready  <= 1'b0;
            res_valid  <= 1'b0;
            res_hit    <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_err   <= 1'b0;
            case (state)
                S_IDLE, S_DEAD: begin
                    if (load) begin
                        if (ships != '0) begin
                            alive_map  <= ships;
                            prev_map   <= '0;
                            shots      <= '0;
                            ships_left <= popcount(ships);
                            live       <= 1'b1;
                            atk_ready  <= 1'b1;
                            state      <= S_ARMED;
                        end else begin
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (atk_valid) begin
                        atk_q     <= atk_map;
                        atk_ready <= 1'b0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    res_valid <= 1'b1;
                    res_err   <= err_c;
                    res_hit   <= !err_c && hit_c;
                    state     <= S_RESULT;
                end
                S_RESULT: begin
                    // res_err/res_hit still hold this shot's verdict during RESULT
                    atk_ready <= 1'b1;
                    state     <= S_ARMED;
                    if (!res_err) begin
                        prev_map   <= atk_q;
                        alive_map  <= alive_nxt_c;
                        shots      <= shots + CNT_W'(1);
                        ships_left <= ships_left - CNT_W'(res_hit);
                        if (alive_nxt_c == '0) begin
                            live      <= 1'b0;
                            atk_ready <= 1'b0;
                            state     <= S_DEAD;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    atk_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt;

    // Turn timer: counts idle ARMED cycles, pulses and rewinds without leaving ARMED.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state != S_ARMED || atk_valid) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                to_cnt  <= '0;
                timeout <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_bs_board_engine.sv
// tb_bs_board_engine: scripted game table, reset/timeout corner cases and random games
// checked against a set-arithmetic model of the board.
module tb_bs_board_engine;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned CNT_W = $clog2(CELLS + 1);

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             load = 1'b0;
    logic [CELLS-1:0] ships = '0;
    logic             atk_valid = 1'b0;
    logic [CELLS-1:0] atk_map = '0;
    logic             atk_ready;
    logic             res_valid;
    logic             res_hit;
    logic             res_err;
    logic [CELLS-1:0] alive_map;
    logic             live;
    logic [CNT_W-1:0] ships_left;
    logic [CNT_W-1:0] shots;
    logic             timeout;

    bs_board_engine #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .clr(clr), .load(load), .ships(ships),
        .atk_valid(atk_valid), .atk_map(atk_map), .atk_ready(atk_ready),
        .res_valid(res_valid), .res_hit(res_hit), .res_err(res_err),
        .alive_map(alive_map), .live(live), .ships_left(ships_left),
        .shots(shots), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference board: 0 idle, 1 armed, 2 dead
    int               m_mode  = 0;
    logic [CELLS-1:0] m_alive = '0;
    logic [CELLS-1:0] m_prev  = '0;
    int               m_shots = 0;

    typedef struct {
        logic [15:0] atk;
        logic        hit;
        logic        err;
        int          left;
        int          nshots;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, atk_ready, 0);
        chk({tag, "_rvalid"}, res_valid, 0);
        chk({tag, "_rhit"}, res_hit, 0);
        chk({tag, "_rerr"}, res_err, 0);
        chk({tag, "_alive"}, alive_map, 0);
        chk({tag, "_live"}, live, 0);
        chk({tag, "_left"}, ships_left, 0);
        chk({tag, "_shots"}, shots, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_alive = '0;
        m_prev  = '0;
        m_shots = 0;
    endtask

    task automatic do_load(input logic [CELLS-1:0] s);
        logic e_rv, e_re;
        e_rv = 1'b0;
        e_re = 1'b0;
        if (m_mode != 1) begin
            if (s == '0) begin
                e_rv = 1'b1;
                e_re = 1'b1;
            end else begin
                m_mode  = 1;
                m_alive = s;
                m_prev  = '0;
                m_shots = 0;
            end
        end
        load  = 1'b1;
        ships = s;
        tick();
        load  = 1'b0;
        ships = CELLS'($urandom);
        chk("load_rvalid", res_valid, e_rv);
        chk("load_rerr", res_err, e_re);
        chk("load_ready", atk_ready, m_mode == 1);
        chk("load_live", live, m_mode == 1);
        tick();
        chk("load_left", ships_left, $countones(m_alive));
        chk("load_shots", shots, m_shots);
        chk("load_alive", alive_map, m_alive);
    endtask

    task automatic do_attack(input logic [CELLS-1:0] atk, output logic o_hit, output logic o_err);
        logic [CELLS-1:0] nw, lost;
        logic e_err, e_hit;
        nw    = atk & ~m_prev;
        lost  = m_prev & ~atk;
        e_err = ($countones(nw) != 1) || (lost != '0);
        e_hit = !e_err && ((nw & m_alive) != '0);
        if (!e_err) begin
            m_prev  = atk;
            m_alive = m_alive & ~nw;
            m_shots++;
            if (m_alive == '0) m_mode = 2;
        end
        chk("pre_ready", atk_ready, 1);
        atk_valid = 1'b1;
        atk_map   = atk;
        tick();
        atk_valid = 1'b0;
        atk_map   = CELLS'($urandom);
        chk("check_ready", atk_ready, 0);
        chk("check_rvalid", res_valid, 0);
        tick();
        o_hit = res_hit;
        o_err = res_err;
        chk("res_valid", res_valid, 1);
        chk("res_hit", res_hit, e_hit);
        chk("res_err", res_err, e_err);
        tick();
        chk("res_pulse", res_valid, 0);
        chk("left", ships_left, $countones(m_alive));
        chk("shots", shots, m_shots);
        chk("alive", alive_map, m_alive);
        chk("live", live, m_mode == 1);
        chk("post_ready", atk_ready, m_mode == 1);
    endtask

    task automatic dead_probe();
        int n_res;
        n_res     = 0;
        atk_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            atk_map = CELLS'($urandom);
            tick();
            if (res_valid) n_res++;
        end
        atk_valid = 1'b0;
        chk("dead_no_result", n_res, 0);
        chk("dead_ready", atk_ready, 0);
        chk("dead_live", live, 0);
    endtask

    function automatic logic [CELLS-1:0] pick_new_cell();
        int start;
        start = $urandom_range(0, CELLS - 1);
        for (int k = 0; k < CELLS; k++) begin
            if (!m_prev[(start + k) % CELLS]) return m_prev | (CELLS'(1) << ((start + k) % CELLS));
        end
        return m_prev;
    endfunction

    initial begin
        logic h, e;
        logic [CELLS-1:0] s, a;
        int n_pulse, first, second;

        tbl[0]  = '{16'h2000, 1'b1, 1'b0, 6, 1};
        tbl[1]  = '{16'h2000, 1'b0, 1'b1, 6, 1};
        tbl[2]  = '{16'h3004, 1'b0, 1'b1, 6, 1};
        tbl[3]  = '{16'h0001, 1'b0, 1'b1, 6, 1};
        tbl[4]  = '{16'h2001, 1'b0, 1'b0, 6, 2};
        tbl[5]  = '{16'h2003, 1'b1, 1'b0, 5, 3};
        tbl[6]  = '{16'h2007, 1'b1, 1'b0, 4, 4};
        tbl[7]  = '{16'h2027, 1'b1, 1'b0, 3, 5};
        tbl[8]  = '{16'h2067, 1'b1, 1'b0, 2, 6};
        tbl[9]  = '{16'h20E7, 1'b1, 1'b0, 1, 7};
        tbl[10] = '{16'h30E7, 1'b1, 1'b0, 0, 8};

        #1 clr = 1'b1;
        #2 chk_reset_outputs("rst");
        tick();
        tick();
        clr = 1'b0;
        model_reset();

        // Idle ignores attacks; an empty ship map is rejected
        atk_valid = 1'b1;
        atk_map   = 16'h0001;
        tick();
        tick();
        atk_valid = 1'b0;
        chk("idle_ready", atk_ready, 0);
        chk("idle_rvalid", res_valid, 0);
        do_load('0);

        do_load(16'h30E6);
        chk("plan_left7", ships_left, 7);
        chk("plan_live", live, 1);
        for (int i = 0; i < 11; i++) begin
            do_attack(tbl[i].atk, h, e);
            chk($sformatf("tbl%0d_hit", i), h, tbl[i].hit);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].err);
            chk($sformatf("tbl%0d_left", i), ships_left, tbl[i].left);
            chk($sformatf("tbl%0d_shots", i), shots, tbl[i].nshots);
            if (i == 0) chk("tbl0_alive", alive_map, 16'h10E6);
        end
        chk("killed_live", live, 0);
        dead_probe();
        do_load(16'h0003);
        chk("restart_shots", shots, 0);
        chk("restart_left", ships_left, 2);
        do_load(16'hFFFF);
        chk("armed_load_ignored", ships_left, 2);

        // Async clear while the shot is in CHECK
        atk_valid = 1'b1;
        atk_map   = 16'h0001;
        tick();
        atk_valid = 1'b0;
        #2 clr = 1'b1;
        #1 chk_reset_outputs("clr_check");
        tick();
        chk("clr_no_result", res_valid, 0);
        clr = 1'b0;
        model_reset();

        // Sit idle in ARMED
        load  = 1'b1;
        ships = 16'h8421;
        tick();
        load    = 1'b0;
        m_mode  = 1;
        m_alive = 16'h8421;
        n_pulse = 0;
        first   = -1;
        second  = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (timeout) begin
                n_pulse++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        chk("idle_armed_ready", atk_ready, 1);
`ifdef TURN_TIMEOUT_EN
        chk("timeout_pulses", n_pulse, 2);
        chk("timeout_first", first, 8);
        chk("timeout_second", second, 16);
`else
        chk("timeout_pulses", n_pulse, 0);
`endif

        // Random games against the model
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_reset();
        for (int g = 0; g < 6; g++) begin
            s = CELLS'($urandom);
            if (g == 0) s = '0;
            do_load(s);
            if (m_mode != 1) continue;
            for (int t = 0; t < 40 && m_mode == 1; t++) begin
                case ($urandom_range(0, 5))
                    0: a = CELLS'($urandom);
                    1: a = m_prev;
                    default: a = pick_new_cell();
                endcase
                do_attack(a, h, e);
            end
            if (m_mode == 2) dead_probe();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
